// File: rtl/rx_usb_pkg.sv
// Shared USB receive-path types and constants.
// Holds the bit-unstuffer state encoding and the USB default run length.
package rx_usb_pkg;

  localparam int unsigned USB_RUN_LEN = 6;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    SKIP,
    ERROR
  } state_type;

endpackage

// File: rtl/rx_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment; the count holds at all-ones.
module rx_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/rx_bit_unstuffer.sv
// USB RX bit unstuffer: counts strobed 1s, flags the stuffed bit after RUN_LEN ones,
// and records stuffing violations and the number of removed bits since the last clear.
module rx_bit_unstuffer
  import rx_usb_pkg::*;
#(
  parameter int unsigned RUN_LEN = USB_RUN_LEN,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             decoded_bit,
  input  logic             bit_valid,
  input  logic             stuff_en,
  input  logic             clear,
  output logic             ignore_bit,
  output logic             stuff_err,
  output logic [CNT_W-1:0] stuff_count
);

  localparam int unsigned RUN_W = $clog2(RUN_LEN + 1);

  state_type        state;
  state_type        state_next;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_next;
  logic [RUN_W-1:0] run_inc;
  logic             err_next;
  logic             cnt_clr;
  logic             cnt_inc;

  assign run_inc    = run_cnt + RUN_W'(1);
  assign ignore_bit = bit_valid & (state == SKIP) & stuff_en & ~clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      run_cnt   <= '0;
      stuff_err <= 1'b0;
    end else begin
      state     <= state_next;
      run_cnt   <= run_next;
      stuff_err <= err_next;
    end
  end

  // Priority: clear, then mode disable, then normal per-state bit handling.
  always_comb begin
    state_next = state;
    run_next   = run_cnt;
    err_next   = stuff_err;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;

    if (clear) begin
      state_next = stuff_en ? COUNT : IDLE;
      run_next   = '0;
      err_next   = 1'b0;
      cnt_clr    = 1'b1;
    end else if (!stuff_en) begin
      state_next = IDLE;
      run_next   = '0;
    end else begin
      case (state)
        IDLE, COUNT: begin
          state_next = COUNT;
          if (bit_valid) begin
            if (!decoded_bit) begin
              run_next = '0;
            end else if (run_inc == RUN_W'(RUN_LEN)) begin
              state_next = SKIP;
              run_next   = '0;
            end else begin
              run_next = run_inc;
            end
          end
        end
        SKIP: begin
          if (bit_valid) begin
            run_next = '0;
            if (!decoded_bit) begin
              state_next = COUNT;
              cnt_inc    = 1'b1;
            end else begin
              state_next = ERROR;
              err_next   = 1'b1;
            end
          end
        end
        ERROR: begin
          err_next = 1'b1;
        end
        default: begin
          state_next = IDLE;
          run_next   = '0;
        end
      endcase
    end
  end

  rx_sat_counter #(
    .W(CNT_W)
  ) u_stuff_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .count(stuff_count)
  );

endmodule

// File: tb/tb_rx_bit_unstuffer.sv
// Directed self-checking bench for rx_bit_unstuffer (default build plus RUN_LEN=1/CNT_W=2 build).
module tb_rx_bit_unstuffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       db = 1'b0, bv = 1'b0, se = 1'b1, clr = 1'b0;
  logic       ign, err;
  logic [7:0] cnt;

  logic       db1 = 1'b0, bv1 = 1'b0, se1 = 1'b1, clr1 = 1'b0;
  logic       ign1, err1;
  logic [1:0] cnt1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rx_bit_unstuffer #(.RUN_LEN(6), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .decoded_bit(db), .bit_valid(bv), .stuff_en(se), .clear(clr),
    .ignore_bit(ign), .stuff_err(err), .stuff_count(cnt)
  );

  rx_bit_unstuffer #(.RUN_LEN(1), .CNT_W(2)) dut_r1 (
    .clk(clk), .rst(rst), .decoded_bit(db1), .bit_valid(bv1), .stuff_en(se1), .clear(clr1),
    .ignore_bit(ign1), .stuff_err(err1), .stuff_count(cnt1)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One strobed bit; ignore_bit is sampled mid-cycle before the capturing edge.
  task automatic send(input bit sel, input logic b, input logic c, input logic exp_ign,
                      input string tag);
    @(negedge clk);
    if (sel) begin
      db1 = b; bv1 = 1'b1;
    end else begin
      db = b; bv = 1'b1; clr = c;
    end
    #1;
    chk(tag, sel ? 16'(ign1) : 16'(ign), 16'(exp_ign));
    @(posedge clk);
    #1;
    bv = 1'b0; bv1 = 1'b0; clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    #1;
    chk("reset_ign", 16'(ign), 16'd0);
    chk("reset_err", 16'(err), 16'd0);
    chk("reset_cnt", 16'(cnt), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // Reset mid-run (counter at 4), then a fresh full run must still stuff.
    for (int i = 0; i < 4; i++) send(0, 1'b1, 1'b0, 1'b0, "prerst_ign");
    @(negedge clk);
    rst = 1'b1;
    bv = 1'b1; db = 1'b1;
    #1;
    chk("rst_ign", 16'(ign), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    chk("rst_cnt", 16'(cnt), 16'd0);
    bv = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Nominal 1111110: only the 7th strobe is ignored.
    for (int i = 0; i < 6; i++) send(0, 1'b1, 1'b0, 1'b0, "nom_run_ign");
    send(0, 1'b0, 1'b0, 1'b1, "nom_stuff_ign");
    chk("nom_cnt", 16'(cnt), 16'd1);
    chk("nom_err", 16'(err), 16'd0);

    pulse_clear();
    chk("clr_cnt", 16'(cnt), 16'd0);

    // Two stuffed runs with 3 idle cycles between strobes.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6; i++) begin
        send(0, 1'b1, 1'b0, 1'b0, "gap_run_ign");
        idle(3);
      end
      send(0, 1'b0, 1'b0, 1'b1, "gap_stuff_ign");
      idle(3);
    end
    chk("gap_cnt", 16'(cnt), 16'd2);

    // Runs of five ones never reach SKIP.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) send(0, 1'b1, 1'b0, 1'b0, "short_ign");
      send(0, 1'b0, 1'b0, 1'b0, "short_zero_ign");
    end
    chk("short_cnt", 16'(cnt), 16'd2);

    // Violation: stuffed bit is 1, error sticks until clear.
    pulse_clear();
    for (int i = 0; i < 6; i++) send(0, 1'b1, 1'b0, 1'b0, "viol_run_ign");
    send(0, 1'b1, 1'b0, 1'b1, "viol_stuff_ign");
    chk("viol_err", 16'(err), 16'd1);
    chk("viol_cnt", 16'(cnt), 16'd0);
    for (int i = 0; i < 20; i++) send(0, logic'((i % 3) != 0), 1'b0, 1'b0, "err_hold_ign");
    chk("err_hold", 16'(err), 16'd1);
    pulse_clear();
    chk("err_cleared", 16'(err), 16'd0);

    // Pass-through mode never ignores or counts.
    se = 1'b0;
    for (int i = 0; i < 6; i++) send(0, 1'b1, 1'b0, 1'b0, "bypass_run_ign");
    send(0, 1'b0, 1'b0, 1'b0, "bypass_stuff_ign");
    chk("bypass_cnt", 16'(cnt), 16'd0);
    chk("bypass_err", 16'(err), 16'd0);
    se = 1'b1;
    idle(1);

    // Clear coincident with the stuffed-bit strobe masks it and is not counted.
    for (int i = 0; i < 6; i++) send(0, 1'b1, 1'b0, 1'b0, "clrco_run_ign");
    send(0, 1'b0, 1'b1, 1'b0, "clrco_stuff_ign");
    chk("clrco_cnt", 16'(cnt), 16'd0);
    chk("clrco_err", 16'(err), 16'd0);
    send(0, 1'b0, 1'b0, 1'b0, "clrco_next_ign");

    // RUN_LEN=1: input 1010 ignores strobes 2 and 4; then saturate CNT_W=2 at 3.
    send(1, 1'b1, 1'b0, 1'b0, "r1_s1_ign");
    send(1, 1'b0, 1'b0, 1'b1, "r1_s2_ign");
    send(1, 1'b1, 1'b0, 1'b0, "r1_s3_ign");
    send(1, 1'b0, 1'b0, 1'b1, "r1_s4_ign");
    chk("r1_cnt2", 16'(cnt1), 16'd2);
    for (int i = 0; i < 3; i++) begin
      send(1, 1'b1, 1'b0, 1'b0, "r1_sat_one_ign");
      send(1, 1'b0, 1'b0, 1'b1, "r1_sat_stuff_ign");
    end
    chk("r1_sat_cnt", 16'(cnt1), 16'd3);
    chk("r1_err", 16'(err1), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rx_bit_unstuffer.md
Name: rx_bit_unstuffer

Overview:
- Parametrised successor to the USB RX bit-stuff detector.
- Sits between the NRZI decoder and the RX shift register in the CDL USB receiver.
- Counts consecutive decoded 1s qualified by a bit strobe. After RUN_LEN ones it flags the next bit for removal and checks that the stuffed bit is 0.
- Adds a stuff-enable mode, a per-packet clear, a sticky stuff-error flag and a saturating removed-bit counter.

Parameters:
RUN_LEN, 6, ones in a row that trigger a stuffed bit; legal range 1..15
CNT_W, 8, width of the stuffed-bit statistics counter; legal range 1..16

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
decoded_bit  input  1  NRZI-decoded bit, valid only when bit_valid=1
bit_valid  input  1  one-cycle strobe per received USB bit
stuff_en  input  1  1 = unstuffing active; 0 = pass-through (never ignore, never error)
clear  input  1  synchronous packet-boundary clear (EOP / SYNC); priority over bit_valid
ignore_bit  output  1  Mealy: stuffed bit present this cycle, shift register must not load it
stuff_err  output  1  registered, sticky: stuffed bit was 1 (bit-stuff violation)
stuff_count  output  CNT_W  registered, saturating count of bits removed since last clear

Behaviour:
- Reset (rst=1, async): state=IDLE, run counter=0, stuff_err=0, stuff_count=0. ignore_bit is 0 while rst=1.
- Run counter: width $clog2(RUN_LEN+1). It changes only on bit_valid=1 cycles. bit_valid=0 cycles hold all state.
- States:
  - IDLE: entered on reset or when stuff_en=0.
    - If stuff_en=1 and bit_valid=1, the bit is processed exactly as in COUNT (no bit lost).
    - If stuff_en=1 and bit_valid=0, go to COUNT with counter=0.
  - COUNT:
    - On bit_valid, decoded_bit=0: counter=0.
    - On bit_valid, decoded_bit=1: counter+1. If counter+1==RUN_LEN, go to SKIP and set counter=0.
  - SKIP (next strobed bit is the stuffed bit):
    - On bit_valid: ignore_bit=1 in that same cycle (combinational).
    - decoded_bit=0: go to COUNT with counter=0. The stuffed 0 never counts as a run bit. stuff_count increments, saturating at 2^CNT_W-1.
    - decoded_bit=1: go to ERROR; stuff_err=1 from the next cycle. stuff_count is not incremented.
  - ERROR:
    - ignore_bit=0 and stuff_err=1 are held.
    - Bits are not counted.
    - Exit only on clear or rst.
- ignore_bit = bit_valid & (state==SKIP) & stuff_en & ~clear.
- stuff_en deasserted in any state: next state IDLE, counter=0. stuff_err and stuff_count are held. ignore_bit is masked immediately, same cycle.
- clear=1 (sync):
  - Next state IDLE if stuff_en=0, else COUNT.
  - counter=0, stuff_err=0, stuff_count=0.
  - A bit_valid in the same cycle is discarded for counting, and ignore_bit is masked.
- Boundaries:
  - RUN_LEN=1: every 1 is followed by a SKIP bit.
  - A run of exactly RUN_LEN-1 ones followed by a 0 never enters SKIP.
  - Back-to-back runs: a stuffed 0 followed by RUN_LEN ones triggers a second SKIP.
  - stuff_count saturates; it does not wrap.
- Latency: ignore_bit has 0 cycles latency relative to the stuffed bit's strobe. stuff_err and stuff_count update 1 cycle after the strobe.

Decomposition:
- Shared package rx_usb_pkg:
  - state_type enum {IDLE, COUNT, SKIP, ERROR}, 2 bits.
  - localparam USB_RUN_LEN=6, used as the default for RUN_LEN.
- Sub-module rx_sat_counter (parameter W; ports clk, rst, clr, inc, count): saturating up-counter for stuff_count.
- Main module holds the FSM and the run counter.

Test Plan:
- Reset: rst pulse mid-run (counter at 4) -> ignore_bit=0, stuff_err=0, stuff_count=0, next six 1s followed by 0 still trigger SKIP.
- Nominal, RUN_LEN=6: strobed bits 1111110 -> ignore_bit=1 only on the 7th strobe, stuff_count=1 one cycle later, stuff_err=0.
- Violation: strobed bits 1111111 -> ignore_bit=1 on the 7th strobe, stuff_err=1 the next cycle and held through 20 more bits until clear=1 drops it to 0.
- Gaps and back-to-back: 6 ones, 0, 6 ones, 0 with 3 idle cycles between strobes -> ignore_bit on strobes 7 and 14 only, stuff_count=2; pattern 111110 repeated -> no ignore_bit.
- Mode and priority:
  - stuff_en=0 during 1111110 -> ignore_bit never asserts, stuff_count stays 0.
  - clear coincident with the stuffed-bit strobe -> ignore_bit=0, stuff_count=0.
- Parameter sweep: RUN_LEN=1 with input 1010 -> ignore_bit on strobes 2 and 4. CNT_W=2 with 5 stuffs -> stuff_count saturates at 3.
